// File: rtl/muldiv_pkg.sv
// Purpose: shared types and constants for the sequential multiply/divide unit.
// Contents: operand width, default iteration count, op encoding, FSM states,
//           small sign helpers used by the top level.
package muldiv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Divides have op[1] set; signed variants have op[0] clear.
  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Purpose: EX-stage <-> multiply/divide unit bundle.
// master: issue side (start/op/op_a/op_b/flush/rd_req/rd_sel out; results in).
// slave : the unit (requests in; rd_data/busy/stall/done/hi/lo out).
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  op_e             op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            rd_req;
  logic            rd_sel;
  logic [XLEN-1:0] rd_data;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, op_a, op_b, flush, rd_req, rd_sel,
    input  rd_data, busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, flush, rd_req, rd_sel,
    output rd_data, busy, stall, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// Purpose: one combinational iteration of the multiply/divide datapath.
// Ports: is_div   - 1 selects restoring divide step, 0 shift-add multiply step
//        acc      - 64-bit accumulator {upper, lower}
//        opnd     - multiplicand (multiply) or divisor (divide)
//        acc_next - accumulator after this step
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] diff;

  always_comb begin
    // Multiply: add multiplicand to upper half when the LSB is set, then shift right.
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : (XLEN+1)'(0));
    // Divide: partial remainder shifted left with the next dividend bit.
    rem_sh = acc[2*XLEN-1:XLEN-1];
    ge     = rem_sh >= {1'b0, opnd};
    // When ge holds the true difference is below opnd, so 32 bits are enough.
    diff   = rem_sh[XLEN-1:0] - opnd;

    if (is_div) begin
      acc_next = ge ? {diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: clk  - clock, rising edge
//        rst  - synchronous active-high reset
//        bus  - muldiv_if.slave: start/op/op_a/op_b issue, flush abort,
//               rd_req/rd_sel/rd_data HI/LO read, busy/stall/done status, hi/lo.
// An accepted op spends ITER cycles in CALC and one in FIX; done pulses the
// cycle after FIX, when hi/lo hold the new result.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  muldiv_if.slave   bus
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   opnd;
  op_e               op_q;
  logic              res_neg;
  logic              rem_neg;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              done_q;
  logic              busy;
  logic              accept;

  logic              sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;

  // Operand magnitudes and signs for the incoming request.
  always_comb begin
    sgn   = is_signed_op(bus.op);
    a_neg = sgn & bus.op_a[XLEN-1];
    b_neg = sgn & bus.op_b[XLEN-1];
    a_abs = neg_if(a_neg, bus.op_a);
    b_abs = neg_if(b_neg, bus.op_b);
  end

  // Next state, accept and stall.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.flush)            state_nxt = S_IDLE;
        else if (cnt == CNT_LAST) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (state == S_CALC) || (state == S_FIX);
  assign bus.busy    = busy;
  assign bus.stall   = busy & (bus.start | bus.rd_req);
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

  muldiv_step u_step (
    .is_div   (is_div(op_q)),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_nxt)
  );

  // All architectural and working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_q    <= OP_MULT;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= bus.op;
            cnt  <= '0;
            if (is_div(bus.op)) begin
              acc     <= {XLEN'(0), a_abs};
              opnd    <= b_abs;
              // Divide by zero keeps the all-ones quotient unsigned.
              res_neg <= (a_neg ^ b_neg) & (bus.op_b != '0);
              rem_neg <= a_neg;
            end else begin
              acc     <= {XLEN'(0), b_abs};
              opnd    <= a_abs;
              res_neg <= a_neg ^ b_neg;
              rem_neg <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            acc <= acc_nxt;
            cnt <= (cnt == CNT_LAST) ? '0 : CNT_W'(cnt + 1'b1);
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_div(op_q)) begin
              lo_q <= neg_if(res_neg, acc[XLEN-1:0]);
              hi_q <= neg_if(rem_neg, acc[2*XLEN-1:XLEN]);
            end else begin
              {hi_q, lo_q} <= res_neg ? (2*XLEN)'(-acc) : acc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: reset, multiply, divide, read/stall,
// flush, mid-operation reset and back-to-back issue.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  muldiv_if bus ();

  muldiv_seq #(.ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] b);
    bus.op    = o;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Edges from accept until done is seen, and busy cycles on the way.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcyc++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd5;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", bus.done); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset hi: got %h expected 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset lo: got %h expected 0", bus.lo); end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multu_max();
    int lat, bc;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL multu latency: got %0d expected 33", lat); end
    n_checks++; if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu hi: got %h expected fffffffe", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu lo: got %h expected 00000001", bus.lo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu busy at done: got %b expected 0", bus.busy); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL multu done pulse width: got %b expected 0", bus.done); end
  endtask

  task automatic test_mult();
    op_e         ops [4];
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vh [4];
    logic [31:0] vl [4];
    int lat, bc;
    ops = '{OP_MULT, OP_MULT, OP_MULT, OP_MULTU};
    va  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vb  = '{32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    vh  = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000, 32'h0000_0001};
    vl  = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], va[i], vb[i]);
      wait_done(lat, bc);
      n_checks++; if (bc != 33) begin n_fail++; $display("FAIL mult[%0d] busy cycles: got %0d expected 33", i, bc); end
      n_checks++; if (bus.hi !== vh[i]) begin n_fail++; $display("FAIL mult[%0d] hi: got %h expected %h", i, bus.hi, vh[i]); end
      n_checks++; if (bus.lo !== vl[i]) begin n_fail++; $display("FAIL mult[%0d] lo: got %h expected %h", i, bus.lo, vl[i]); end
      tick();
    end
  endtask

  task automatic test_div();
    op_e         ops [7];
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vh [7];
    logic [31:0] vl [7];
    int lat, bc;
    ops = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    va  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB, 32'd100, 32'd7, 32'hFFFF_FFFF};
    vb  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd7, 32'hFFFF_FFFE, 32'd2};
    vh  = '{32'hFFFF_FFFF, 32'd7, 32'h0, 32'hFFFF_FFFB, 32'd2, 32'd1, 32'd1};
    vl  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFD, 32'h7FFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], va[i], vb[i]);
      wait_done(lat, bc);
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div[%0d] latency: got %0d expected 33", i, lat); end
      n_checks++; if (bus.hi !== vh[i]) begin n_fail++; $display("FAIL div[%0d] hi: got %h expected %h", i, bus.hi, vh[i]); end
      n_checks++; if (bus.lo !== vl[i]) begin n_fail++; $display("FAIL div[%0d] lo: got %h expected %h", i, bus.lo, vl[i]); end
      tick();
    end
  endtask

  task automatic test_rd_stall();
    int lat, nb, ns;
    issue(OP_MULTU, 32'h0001_0000, 32'h0003_0005);
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    lat = 0; nb = 0; ns = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) begin
        nb++;
        if (bus.stall === 1'b1) ns++;
      end
      tick();
      lat++;
    end
    n_checks++; if (nb != 33) begin n_fail++; $display("FAIL rd busy cycles: got %0d expected 33", nb); end
    n_checks++; if (ns != 33) begin n_fail++; $display("FAIL rd stall cycles: got %0d expected 33", ns); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rd stall at done: got %b expected 0", bus.stall); end
    n_checks++; if (bus.rd_data !== 32'h0000_0003) begin n_fail++; $display("FAIL rd hi at done: got %h expected 00000003", bus.rd_data); end
    bus.rd_sel = 1'b0;
    #1;
    n_checks++; if (bus.rd_data !== 32'h0005_0000) begin n_fail++; $display("FAIL rd lo at done: got %h expected 00050000", bus.rd_data); end
    bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int lat, bc;
    // Flush in IDLE together with start: nothing happens.
    bus.op = OP_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7;
    bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush idle start busy: got %b expected 0", bus.busy); end
    // Flush at iteration 10 of a DIV.
    issue(OP_DIV, 32'd200, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush calc busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush calc done: got %b expected 0", bus.done); end
    n_checks++; if (bus.hi !== 32'h0000_0003) begin n_fail++; $display("FAIL flush calc hi: got %h expected 00000003", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0005_0000) begin n_fail++; $display("FAIL flush calc lo: got %h expected 00050000", bus.lo); end
    // Start on the very next cycle runs the full latency.
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL flush restart latency: got %0d expected 33", lat); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL flush restart lo: got %h expected 0000000e", bus.lo); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL flush restart hi: got %h expected 00000002", bus.hi); end
    tick();
    // Flush while in FIX discards the result.
    issue(OP_DIVU, 32'd200, 32'd7);
    for (int i = 0; i < 32; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush fix done: got %b expected 0", bus.done); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL flush fix lo: got %h expected 0000000e", bus.lo); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL flush fix hi: got %h expected 00000002", bus.hi); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL midrst hi: got %h expected 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL midrst lo: got %h expected 0", bus.lo); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst done: got %b expected 0", bus.done); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, nb, ns, bc;
    bus.op = OP_MULTU; bus.op_a = 32'd3; bus.op_b = 32'd5;
    bus.start = 1'b1;
    tick();
    // Second request held on the bus while the first runs.
    bus.op = OP_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7;
    lat = 0; nb = 0; ns = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) begin
        nb++;
        if (bus.stall === 1'b1) ns++;
      end
      tick();
      lat++;
    end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b first latency: got %0d expected 33", lat); end
    n_checks++; if (ns != 33) begin n_fail++; $display("FAIL b2b stall cycles: got %0d expected 33", ns); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b stall at done: got %b expected 0", bus.stall); end
    n_checks++; if (bus.lo !== 32'd15) begin n_fail++; $display("FAIL b2b first lo: got %h expected 0000000f", bus.lo); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL b2b first hi: got %h expected 0", bus.hi); end
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b second accept busy: got %b expected 1", bus.busy); end
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b second latency: got %0d expected 33", lat); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL b2b second lo: got %h expected 0000000e", bus.lo); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL b2b second hi: got %h expected 00000002", bus.hi); end
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = OP_MULT;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.flush  = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
    test_reset();
    test_multu_max();
    test_mult();
    test_div();
    test_rd_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
